uart_sample_rx: RTL

UART_SAMPLE_RX -- requirements
Module: uart_sample_rx

---
 rtl/uart_sample_if.sv | 32 +++
 rtl/uart_sample_rx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_sample_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_sample_if
// Purpose  : Sample output handshake bundle (data, channel, valid/ready).
// Revision : 1.0
// ============================================================================
interface uart_sample_if #(
    parameter int SAMPLE_BYTES = 2,
    parameter int CHANNELS     = 2
);
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [8*SAMPLE_BYTES-1:0] sample_data;
    logic [CHAN_W-1:0]         sample_chan;
    logic                      sample_valid;
    logic                      sample_ready;

    modport master (
        output sample_data,
        output sample_chan,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_chan,
        input  sample_valid,
        output sample_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_sample_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_sample_rx
// Purpose  : 8N1 UART receiver assembling little-endian multi-byte samples
//            across interleaved channels with valid/ready output.
// Revision : 1.0
// ============================================================================
module uart_sample_rx #(
    parameter int CLKS_PER_BIT     = 31,
    parameter int SAMPLE_BYTES     = 2,
    parameter int CHANNELS         = 2,
    parameter int IDLE_RESYNC_BITS = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          uart_rx,
    output logic          frame_err,
    output logic          overrun_err,
    uart_sample_if.master smp
);
    localparam int CNT_W      = $clog2(CLKS_PER_BIT);
    localparam int CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BIDX_W     = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
    localparam int SW         = 8 * SAMPLE_BYTES;
    localparam int IDLE_LIMIT = IDLE_RESYNC_BITS * CLKS_PER_BIT;
    localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);

    localparam logic [CNT_W-1:0]  HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(SAMPLE_BYTES - 1);
    localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              state_q;
    logic [1:0]          sync_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          bit_q;
    logic [7:0]          shift_q;
    logic [BIDX_W-1:0]   byte_idx_q;
    logic [CHAN_W-1:0]   chan_q;
    logic [SW-1:0]       acc_q;
    logic [IDLE_W-1:0]   idle_cnt_q;
    logic                valid_q;
    logic [SW-1:0]       data_q;
    logic [CHAN_W-1:0]   chan_out_q;
    logic                frame_err_q;
    logic                overrun_q;

    logic                rx_s;
    logic [SW-1:0]       sample_d;
    logic [CHAN_W-1:0]   chan_d;

    assign rx_s = sync_q[1];

    // Partial sample with the byte currently in the shifter dropped into its slot.
    always_comb begin
        sample_d = acc_q;
        for (int k = 0; k < SAMPLE_BYTES; k++) begin
            if (byte_idx_q == BIDX_W'(k)) begin
                sample_d[8*k +: 8] = shift_q;
            end
        end
    end

    assign chan_d = (chan_q == LAST_CHAN) ? '0 : chan_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            byte_idx_q  <= '0;
            chan_q      <= '0;
            acc_q       <= '0;
            idle_cnt_q  <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            chan_out_q  <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], uart_rx};
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            if (valid_q && smp.sample_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_q    <= S_START;
                        cnt_q      <= '0;
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q != IDLE_W'(IDLE_LIMIT)) begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                        // A long quiet line means the sender restarted its stream.
                        if (idle_cnt_q == IDLE_W'(IDLE_LIMIT - 1)) begin
                            byte_idx_q <= '0;
                            chan_q     <= '0;
                        end
                    end
                end

                S_START: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        state_q <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_STOP: begin
                    if (cnt_q == LAST_CNT) begin
                        // Leave at mid stop bit so a back-to-back start edge is not missed.
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        if (rx_s) begin
                            acc_q <= sample_d;
                            if (byte_idx_q == LAST_BYTE) begin
                                byte_idx_q <= '0;
                                chan_q     <= chan_d;
                                if (!valid_q || smp.sample_ready) begin
                                    valid_q    <= 1'b1;
                                    data_q     <= sample_d;
                                    chan_out_q <= chan_q;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end else begin
                                byte_idx_q <= byte_idx_q + 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            byte_idx_q  <= '0;
                            chan_q      <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign smp.sample_valid = valid_q;
    assign smp.sample_data  = data_q;
    assign smp.sample_chan  = chan_out_q;
    assign frame_err        = frame_err_q;
    assign overrun_err      = overrun_q;

endmodule
`default_nettype wire
